// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with sub-word read-modify-write
module mem_access_unit #(
  parameter int MEM_WORDS = 64,
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] readData
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_DONE, S_ERR_DONE
  } state_t;

  state_t      state_q;
  logic        resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic [31:0] resp_rdata_q, address_q, write_data_q;
  logic [1:0]  size_q, off_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;

  logic        size_err, align_err, range_err, req_err;
  logic [31:0] word_addr;
  logic [31:0] rd_shifted, load_ext, merged;

  // Classify the incoming request and form the DATAMEMORY address
  always_comb begin
    size_err  = (req_size == 2'b11);
    align_err = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    req_err   = size_err | align_err | range_err;
    word_addr = WORD_ADDR ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};
  end

  // Extract/extend the load lane and merge the store lane into the read word
  always_comb begin
    rd_shifted = readData >> {off_q, 3'b000};
    load_ext   = readData;
    merged     = readData;
    case (size_q)
      2'b00: begin
        load_ext = {{24{~unsigned_q & rd_shifted[7]}}, rd_shifted[7:0]};
        merged   = (readData & ~(32'h0000_00FF << {off_q, 3'b000})) |
                   ({24'd0, wdata_q[7:0]} << {off_q, 3'b000});
      end
      2'b01: begin
        // off_q[0] is always 0 here: misaligned halves never leave IDLE
        load_ext = {{16{~unsigned_q & rd_shifted[15]}}, rd_shifted[15:0]};
        merged   = (readData & ~(32'h0000_FFFF << {off_q, 3'b000})) |
                   ({16'd0, wdata_q} << {off_q, 3'b000});
      end
      default: ;
    endcase
  end

  // Access sequencer; every memory-side and response output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_rdata_q <= 32'd0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 16'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            off_q      <= req_addr[1:0];
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            if (req_err) begin
              state_q      <= S_ERR_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              address_q <= word_addr;
              if (!req_write) begin
                state_q    <= S_LOAD;
                mem_read_q <= 1'b1;
              end else if (req_size == 2'b10) begin
                state_q      <= S_STORE;
                mem_write_q  <= 1'b1;
                write_data_q <= req_wdata;
              end else begin
                state_q    <= S_RMW_RD;
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          mem_read_q   <= 1'b0;
          resp_rdata_q <= load_ext;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_STORE: begin
          mem_write_q  <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_RMW_RD: begin
          // write_data_q doubles as the merge register for the write-back cycle
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b1;
          write_data_q <= merged;
          state_q      <= S_RMW_WR;
        end
        S_RMW_WR: begin
          mem_write_q  <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE, S_ERR_DONE: state_q <= S_IDLE;
        default:            state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign writeData  = write_data_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;

endmodule
